// File: rtl/alu_seq_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU core.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_ACC = 3'd5;
    localparam logic [2:0] OP_CLR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add multiplier: one partial-product step per clock, WIDTH steps per operation.
// `product` presents the completed product combinationally during the final step
// so the caller can register it on the same edge that `done` is high.
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] prod_reg;
    logic [2*WIDTH-1:0] prod_next;
    logic [CW-1:0]      cnt_reg;
    logic               busy_reg;

    // Partial product after adding the current shifted multiplicand when the multiplier LSB is set
    always_comb begin
        prod_next = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
    end

    // Operand load on start, then one shift-add step per edge until the last step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
        end else if (start) begin
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            prod_reg   <= prod_next;
            mplier_reg <= mplier_reg >> 1;
            mcand_reg  <= mcand_reg << 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_STEP) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign done    = busy_reg && (cnt_reg == LAST_STEP);
    assign product = prod_next;

endmodule

// File: rtl/alu_seq_core.sv
// Registered ALU with valid/ready input, running accumulator and a multi-cycle multiply.
// Single-cycle ops complete on the transfer edge; MUL parks the FSM in ST_MUL for WIDTH edges.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             out_valid,
    output logic [WIDTH-1:0] acc
);

    state_t state_reg;
    state_t state_next;

    logic               xfer;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     sum_ab;
    logic [WIDTH:0]     diff_ab;
    logic [WIDTH:0]     acc_sum;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_carry;
    logic [WIDTH-1:0]   acc_next;

    logic [WIDTH-1:0]   result_reg;
    logic               carry_reg;
    logic               zero_reg;
    logic               out_valid_reg;
    logic [WIDTH-1:0]   acc_reg;

    assign xfer      = in_valid && in_ready;
    assign mul_start = xfer && (op == OP_MUL);

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: enter ST_MUL on a MUL transfer, leave on the final multiplier step
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (mul_start) state_next = ST_MUL;
            ST_MUL:  if (mul_done)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: ready depends on state alone, never on in_valid
    always_comb begin
        in_ready = (state_reg == ST_IDLE);
    end

    // Single-cycle datapath: result, flag and accumulator update for ops 0-6
    always_comb begin
        sum_ab     = {1'b0, a} + {1'b0, b};
        diff_ab    = {1'b0, a} - {1'b0, b};
        acc_sum    = {1'b0, acc_reg} + {1'b0, a};
        alu_result = '0;
        alu_carry  = 1'b0;
        acc_next   = acc_reg;
        case (op)
            OP_ADD: begin
                alu_result = sum_ab[WIDTH-1:0];
                alu_carry  = sum_ab[WIDTH];
            end
            OP_SUB: begin
                alu_result = diff_ab[WIDTH-1:0];
                alu_carry  = diff_ab[WIDTH];
            end
            OP_AND: alu_result = a & b;
            OP_OR:  alu_result = a | b;
            OP_XOR: alu_result = a ^ b;
            OP_ACC: begin
                alu_result = acc_sum[WIDTH-1:0];
                alu_carry  = acc_sum[WIDTH];
                acc_next   = acc_sum[WIDTH-1:0];
            end
            OP_CLR: begin
                alu_result = '0;
                acc_next   = '0;
            end
            default: begin
                alu_result = '0;
                alu_carry  = 1'b0;
            end
        endcase
    end

    // Output registers: load from the single-cycle path on a transfer, or from the multiplier on its last step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_reg    <= '0;
            carry_reg     <= 1'b0;
            zero_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            acc_reg       <= '0;
        end else begin
            out_valid_reg <= 1'b0;
            if (xfer && (op != OP_MUL)) begin
                result_reg    <= alu_result;
                carry_reg     <= alu_carry;
                zero_reg      <= (alu_result == '0);
                out_valid_reg <= 1'b1;
                acc_reg       <= acc_next;
            end else if ((state_reg == ST_MUL) && mul_done) begin
                result_reg    <= mul_product[WIDTH-1:0];
                carry_reg     <= |mul_product[2*WIDTH-1:WIDTH];
                zero_reg      <= (mul_product[WIDTH-1:0] == '0);
                out_valid_reg <= 1'b1;
            end
        end
    end

    assign result    = result_reg;
    assign carry     = carry_reg;
    assign zero      = zero_reg;
    assign out_valid = out_valid_reg;
    assign acc       = acc_reg;

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core (WIDTH=8): directed scenarios with literal expectations plus a
// randomized stream, all cross-checked every cycle against a transaction-level model.
module tb_alu_seq_core;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         out_valid;
    logic [W-1:0] acc;

    int n_checks = 0;
    int n_pass   = 0;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .out_valid (out_valid),
        .acc       (acc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Transaction view: each accepted op yields its arithmetic answer one edge later,
    // except MUL which yields a*b after W busy edges during which nothing is accepted.
    int m_result = 0, m_carry = 0, m_zero = 0, m_valid = 0, m_acc = 0;
    int m_busy = 0, pend_r = 0, pend_c = 0;
    bit m_started = 0;

    always @(posedge clk) begin
        int av, bv, r;
        av = int'(a);
        bv = int'(b);
        m_started = 1;
        if (!rst_n) begin
            m_result = 0; m_carry = 0; m_zero = 0; m_valid = 0; m_acc = 0; m_busy = 0;
        end else begin
            m_valid = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_result = pend_r; m_carry = pend_c; m_zero = (pend_r == 0); m_valid = 1;
                end
            end else if (in_valid) begin
                if (op == 3'd7) begin
                    r = av * bv;
                    pend_r = r % 256;
                    pend_c = (r / 256) != 0;
                    m_busy = W;
                end else begin
                    case (op)
                        3'd0: begin r = av + bv; m_result = r % 256; m_carry = r / 256; end
                        3'd1: begin m_result = (av - bv + 256) % 256; m_carry = av < bv; end
                        3'd2: begin m_result = av & bv; m_carry = 0; end
                        3'd3: begin m_result = av | bv; m_carry = 0; end
                        3'd4: begin m_result = av ^ bv; m_carry = 0; end
                        3'd5: begin r = m_acc + av; m_acc = r % 256; m_result = m_acc; m_carry = r / 256; end
                        default: begin m_acc = 0; m_result = 0; m_carry = 0; end
                    endcase
                    m_zero  = (m_result == 0);
                    m_valid = 1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (m_started) begin
            check("cyc_result",    result,    m_result);
            check("cyc_carry",     carry,     m_carry);
            check("cyc_zero",      zero,      m_zero);
            check("cyc_out_valid", out_valid, m_valid);
            check("cyc_acc",       acc,       m_acc);
            check("cyc_in_ready",  in_ready,  (m_busy == 0) ? 1 : 0);
        end
    end

    // ---------------- directed helpers ----------------
    // Present one op after the next falling edge and hold until accepted (bounded);
    // returns just after the transfer edge with in_valid dropped.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic r;
        bit ok;
        ok = 0;
        @(negedge clk);
        #1;
        op = o; a = x; b = y; in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r = in_ready;
            @(posedge clk);
            if (r) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        #1 in_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    initial begin
        int low, c;

        // Reset state
        @(negedge clk);
        check("rst_result", result, 0);
        check("rst_carry", carry, 0);
        check("rst_zero", zero, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_acc", acc, 0);
        check("rst_in_ready", in_ready, 1);
        #1 rst_n = 1'b1;

        // ADD with carry-out, SUB with borrow
        do_op(3'd0, 8'hF0, 8'h20);
        @(negedge clk);
        check("add_valid", out_valid, 1);
        check("add_result", result, 8'h10);
        check("add_carry", carry, 1);
        check("add_zero", zero, 0);
        do_op(3'd1, 8'h05, 8'h07);
        @(negedge clk);
        check("sub_result", result, 8'hFE);
        check("sub_carry", carry, 1);

        // Accumulator: CLR, ACC 0x80, XOR (acc untouched), ACC 0x80 wraps
        do_op(3'd6, 8'h55, 8'h66);
        @(negedge clk);
        check("clr_acc", acc, 0);
        do_op(3'd5, 8'h80, 8'h00);
        @(negedge clk);
        check("acc1_result", result, 8'h80);
        check("acc1_carry", carry, 0);
        do_op(3'd4, 8'h3C, 8'h3C);
        @(negedge clk);
        check("xor_result", result, 8'h00);
        check("xor_zero", zero, 1);
        check("xor_acc_kept", acc, 8'h80);
        do_op(3'd5, 8'h80, 8'h00);
        @(negedge clk);
        check("acc2_result", result, 8'h00);
        check("acc2_carry", carry, 1);
        check("acc2_zero", zero, 1);
        check("acc2_acc", acc, 8'h00);

        // MUL 0x0F*0x11: in_ready low exactly 8 cycles, result in 9th cycle after transfer
        do_op(3'd7, 8'h0F, 8'h11);
        low = 0; c = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            c++;
            if (!in_ready) low++;
            if (out_valid) break;
        end
        check("mul1_ready_low", low, 8);
        check("mul1_latency", c, 9);
        check("mul1_result", result, 8'hFF);
        check("mul1_carry", carry, 0);
        check("mul1_in_ready", in_ready, 1);

        do_op(3'd7, 8'h10, 8'h10);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("mul2_result", result, 8'h00);
        check("mul2_carry", carry, 1);
        check("mul2_zero", zero, 1);

        // ADD held valid during MUL: accepted only in the MUL completion cycle
        do_op(3'd7, 8'h03, 8'h05);
        op = 3'd0; a = 8'h01; b = 8'h02; in_valid = 1'b1;
        c = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            c++;
            if (out_valid) break;
        end
        check("hold_mul_latency", c, 9);
        check("hold_mul_result", result, 8'h0F);
        check("hold_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("hold_add_valid", out_valid, 1);
        check("hold_add_result", result, 8'h03);

        // Reset on step 4 of a MUL aborts it
        do_op(3'd7, 8'h0F, 8'h11);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_acc", acc, 0);
        check("abort_in_ready", in_ready, 1);
        repeat (10) @(negedge clk);
        do_op(3'd0, 8'h01, 8'h01);
        @(negedge clk);
        check("post_abort_add", result, 8'h02);

        // Randomized stream with gaps and occasional reset
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            #1;
            rst_n    = ($urandom_range(0, 199) != 0);
            in_valid = ($urandom_range(0, 2) != 0);
            op       = 3'($urandom_range(0, 7));
            a        = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            b        = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        end
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised, registered arithmetic/logic unit with a running accumulator and a multi-cycle shift-add multiplier. It is the successor to our combinational add/xor/and datapath on the tiny-tile user pins: operands and opcode arrive with a valid/ready handshake, and results leave registered with flags. It sits between the pin-mapping wrapper, which drives `a`/`b`/`op` from the dedicated and bidirectional inputs, and the output pins.

## Interface
- `WIDTH`, default 8: operand, result and accumulator width, minimum 2.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operand/opcode present.
- `in_ready`  out  1  block can accept; a transfer occurs on an edge where `in_valid & in_ready`.
- `op`  in  3  opcode, sampled at transfer.
- `a`, `b`  in  WIDTH  operands, sampled at transfer.
- `result`  out  WIDTH  registered result.
- `carry`  out  1  carry / borrow / overflow flag.
- `zero`  out  1  `result == 0`.
- `out_valid`  out  1  one-cycle pulse: result/flags updated this cycle.
- `acc`  out  WIDTH  current accumulator value.

## Operation
Opcodes:
- 0 ADD: `a+b` mod 2^WIDTH; carry = carry-out.
- 1 SUB: `a-b` mod 2^WIDTH; carry = borrow (`a<b`).
- 2 AND, 3 OR, 4 XOR: bitwise; carry = 0.
- 5 ACC: `acc <= acc+a`; result = new acc; carry = carry-out.
- 6 CLR: `acc <= 0`; result = 0; carry = 0.
- 7 MUL: result = low WIDTH bits of `a*b`; carry = 1 if the high WIDTH bits are nonzero.

General rules:
- `zero` is always derived from the result value being registered.
- `acc` changes only on ACC or CLR.
- All other opcodes leave `acc` unchanged.

FSM:
- IDLE: `in_ready=1`.
  - A transfer with op 0–6 registers result, flags and acc on that edge and stays in IDLE.
  - A transfer with op 7 loads the multiplier registers and goes to MUL.
- MUL: `in_ready=0`. Each edge runs one shift-add step:
  - the 2·WIDTH product adds the shifted multiplicand if the multiplier LSB is 1;
  - the multiplier shifts right and the multiplicand shifts left;
  - the step counter increments.
- On step WIDTH−1 the edge registers result/carry/zero and returns to IDLE.
- `in_valid` while in MUL is ignored. Operands are not re-sampled.

Reset (`rst_n=0` at an edge):
- `result=0`, `carry=0`, `zero=0`, `out_valid=0`, `acc=0`, state IDLE, counter 0.
- `in_ready=1` in the cycle after reset.
- Reset during MUL aborts the operation with no `out_valid`.

## Timing
- `in_ready` is combinational from state only and never depends on `in_valid`.
- Ops 0–6: transfer at edge E0 gives `out_valid=1` in the cycle after E0, latency 1. Back-to-back transfers every cycle are allowed.
- MUL: transfer at E0 gives WIDTH step edges E1..E_WIDTH.
  - `in_ready=0` for exactly WIDTH cycles.
  - `out_valid=1` and `in_ready=1` in the cycle after E_WIDTH.
  - A new transfer is accepted in that same cycle.
- `out_valid` is a pulse with no backpressure. `result`, `carry` and `zero` hold until the next update.

## Structure
- Package `alu_seq_pkg` holds:
  - the opcode constants (`OP_ADD`..`OP_MUL`);
  - the FSM state encoding (`ST_IDLE`, `ST_MUL`).
- Sub-module `alu_seq_mul` holds the shift-add multiplier:
  - multiplicand, multiplier, product and counter registers;
  - inputs `start` and `a`/`b`; outputs `done` and the 2·WIDTH product.
- `alu_seq_core` holds the FSM, the single-cycle ops, the accumulator and the output registers.

## Test plan
All scenarios use WIDTH=8.
- ADD `a=0xF0`, `b=0x20` → next cycle `out_valid=1`, `result=0x10`, `carry=1`, `zero=0`; SUB `0x05-0x07` → `0xFE`, `carry=1`.
- CLR, then ACC `a=0x80` twice → results `0x80` (`carry=0`), then `0x00` with `carry=1`, `zero=1`, `acc=0x00`; an XOR in between leaves `acc` unchanged.
- MUL `0x0F*0x11` → `in_ready` low exactly 8 cycles, `out_valid` 8 cycles after transfer edge + 1, `result=0xFF`, `carry=0`; MUL `0x10*0x10` → `0x00`, `carry=1`, `zero=1`.
- `in_valid` held high with ADD operands during MUL → not accepted; the ADD transfers in the cycle `out_valid` for MUL is high, and its result appears the following cycle.
- `rst_n` low on step 4 of a MUL → no `out_valid`; all outputs 0, `in_ready=1` next cycle; a following ADD `1+1` → `0x02`.
- Random op/operand stream with random `in_valid` gaps, checked against a reference model including `acc`, flags and latency.
